fft_reorder: RTL and testbench

- Output reorder buffer sitting directly downstream of the last fftstg in the radix-2 SDF pipeline.
- The pipeline emits each 2^N-point frame in bit-reversed order, tagged by cnt; this block re-emits every frame in natural order.
- Ping-pong memory (two banks of 2^N complex words) so a continuous input stream produces a continuous output stream.
- Output interface matches the stage interface (en/cnt/re/im), so downstream logic sees the same conventions.

---
 rtl/fft_reorder_if.sv | 30 +++
 rtl/fft_reorder.sv | 115 +++++++++++
 tb/tb_fft_reorder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_reorder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_reorder_if : stage-style stream bus (en/cnt/re/im) in and out  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface fft_reorder_if #(
  parameter int WIDTH = 16,
  parameter int N     = 6
);
  logic                    en_in;
  logic [N-1:0]            cnt_in;
  logic signed [WIDTH-1:0] xin_re;
  logic signed [WIDTH-1:0] xin_im;
  logic                    en_out;
  logic [N-1:0]            cnt_out;
  logic signed [WIDTH-1:0] yout_re;
  logic signed [WIDTH-1:0] yout_im;
  logic                    busy;

  modport master (
    output en_in, cnt_in, xin_re, xin_im,
    input  en_out, cnt_out, yout_re, yout_im, busy
  );

  modport slave (
    input  en_in, cnt_in, xin_re, xin_im,
    output en_out, cnt_out, yout_re, yout_im, busy
  );
endinterface
`default_nettype wire

// File: rtl/fft_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fft_reorder : ping-pong buffer turning bit-reversed FFT frames     |
// |               into natural-order frames                            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fft_reorder #(
  parameter int WIDTH = 16,
  parameter int N     = 6
) (
  input  wire logic clk,
  input  wire logic areset,
  fft_reorder_if.slave bus_if
);
  localparam int           DEPTH     = 1 << N;
  localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                  state_q;
  logic                    wbank_q;
  logic                    rbank_q;
  logic                    pending_q;
  logic                    pend_bank_q;
  logic [N-1:0]            rd_cnt_q;
  logic                    en_out_q;
  logic [N-1:0]            cnt_out_q;
  logic signed [WIDTH-1:0] yout_re_q;
  logic signed [WIDTH-1:0] yout_im_q;

  // Bank number is the MSB of the address: {bank, offset}.
  logic [2*WIDTH-1:0]      mem_q [0:2*DEPTH-1];

  logic [N-1:0]            w_wr_addr;
  logic                    w_frame_done;
  logic [2*WIDTH-1:0]      w_rd_word;

  for (genvar i = 0; i < N; i++) begin : g_bitrev
    assign w_wr_addr[i] = bus_if.cnt_in[N-1-i];
  end

  assign w_frame_done = bus_if.en_in && (bus_if.cnt_in == LAST_ADDR);
  assign w_rd_word    = mem_q[{rbank_q, rd_cnt_q}];

  always_ff @(posedge clk) begin
    if (bus_if.en_in) begin
      mem_q[{wbank_q, w_wr_addr}] <= {bus_if.xin_re, bus_if.xin_im};
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q     <= IDLE;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      pending_q   <= 1'b0;
      pend_bank_q <= 1'b0;
      rd_cnt_q    <= '0;
      en_out_q    <= 1'b0;
      cnt_out_q   <= '0;
      yout_re_q   <= '0;
      yout_im_q   <= '0;
    end else begin
      en_out_q <= (state_q == READ);
      if (w_frame_done) begin
        wbank_q <= ~wbank_q;
      end
      case (state_q)
        IDLE: begin
          if (w_frame_done) begin
            state_q  <= READ;
            rbank_q  <= wbank_q;
            rd_cnt_q <= '0;
          end else if (pending_q) begin
            state_q   <= READ;
            rbank_q   <= pend_bank_q;
            rd_cnt_q  <= '0;
            pending_q <= 1'b0;
          end
        end
        READ: begin
          yout_re_q <= w_rd_word[2*WIDTH-1:WIDTH];
          yout_im_q <= w_rd_word[WIDTH-1:0];
          cnt_out_q <= rd_cnt_q;
          rd_cnt_q  <= rd_cnt_q + 1'b1;
          // At the last address a waiting frame is picked up without a gap.
          if (rd_cnt_q == LAST_ADDR) begin
            if (w_frame_done) begin
              rbank_q <= wbank_q;
            end else if (pending_q) begin
              rbank_q   <= pend_bank_q;
              pending_q <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else if (w_frame_done) begin
            pending_q   <= 1'b1;
            pend_bank_q <= wbank_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.en_out  = en_out_q;
  assign bus_if.cnt_out = cnt_out_q;
  assign bus_if.yout_re = yout_re_q;
  assign bus_if.yout_im = yout_im_q;
  assign bus_if.busy    = (state_q == READ);
endmodule
`default_nettype wire

// File: tb/tb_fft_reorder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fft_reorder : directed bench for fft_reorder with N=3, WIDTH=16 |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fft_reorder;
  localparam int W  = 16;
  localparam int NB = 3;

  typedef logic signed [31:0] v_t;

  logic clk    = 1'b0;
  logic areset = 1'b1;

  always #5 clk = ~clk;

  fft_reorder_if #(.WIDTH(W), .N(NB)) bus ();

  fft_reorder #(.WIDTH(W), .N(NB)) dut (
    .clk    (clk),
    .areset (areset),
    .bus_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  v_t cap_cnt[$];
  v_t cap_re[$];
  v_t cap_im[$];
  v_t cap_cyc[$];

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    v_t t;
    @(negedge clk);
    cyc++;
    if (bus.en_out === 1'b1) begin
      t = $signed(bus.yout_re); cap_re.push_back(t);
      t = $signed(bus.yout_im); cap_im.push_back(t);
      cap_cnt.push_back(v_t'(bus.cnt_out));
      cap_cyc.push_back(cyc);
    end
  endtask

  task automatic drive(input logic en, input int c, input int re, input int im);
    bus.en_in  = en;
    bus.cnt_in = c[NB-1:0];
    bus.xin_re = re[W-1:0];
    bus.xin_im = im[W-1:0];
  endtask

  task automatic clear_cap();
    cap_cnt.delete();
    cap_re.delete();
    cap_im.delete();
    cap_cyc.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_en_out"},  v_t'(bus.en_out),  0);
    chk({tag, "_busy"},    v_t'(bus.busy),    0);
    chk({tag, "_cnt_out"}, v_t'(bus.cnt_out), 0);
    chk({tag, "_yout_re"}, $signed(bus.yout_re), 0);
    chk({tag, "_yout_im"}, $signed(bus.yout_im), 0);
  endtask

  // Bin b of frame f is expected to carry re = b*100 + offset, im = -re.
  task automatic check_burst(input string tag, input int start, input int n,
                             input int off0, input int off1);
    int re;
    chk({tag, "_count"}, cap_cnt.size(), n);
    for (int i = 0; i < n && i < cap_cnt.size(); i++) begin
      re = (i % 8) * 100 + ((i < 8) ? off0 : off1);
      chk({tag, "_cycle"}, cap_cyc[i], start + i);
      chk({tag, "_cnt"},   cap_cnt[i], i % 8);
      chk({tag, "_re"},    cap_re[i],  re);
      chk({tag, "_im"},    cap_im[i],  -re);
    end
  endtask

  function automatic int bitrev3(input int v);
    return ((v & 1) * 4) + (v & 2) + ((v >> 2) & 1);
  endfunction

  initial begin
    int last;
    int v;
    int kk;
    drive(1'b0, 0, 0, 0);
    #1 areset = 1'b0;
    repeat (3) tick();
    chk_outputs_zero("reset");
    areset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_outputs_zero("idle");
    end

    // One continuous frame
    clear_cap();
    for (int k = 0; k < 8; k++) begin
      tick();
      drive(1'b1, k, bitrev3(k) * 100, -bitrev3(k) * 100);
    end
    last = cyc;
    tick();
    drive(1'b0, 7, 0, 0);
    chk("s1_busy_after_done", v_t'(bus.busy), 1);
    chk("s1_en_out_after_done", v_t'(bus.en_out), 0);
    repeat (12) tick();
    check_burst("s1", last + 2, 8, 0, 0);

    // Two back-to-back frames
    clear_cap();
    last = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      kk = k % 8;
      v  = bitrev3(kk) * 100 + ((k >= 8) ? 1000 : 0);
      drive(1'b1, kk, v, -v);
      if (k == 7) last = cyc;
    end
    tick();
    drive(1'b0, 7, 0, 0);
    repeat (20) tick();
    check_burst("s2", last + 2, 16, 0, 1000);

    // Valid every other cycle; gap cycles carry junk that must not be written
    clear_cap();
    for (int k = 0; k < 8; k++) begin
      tick();
      drive(1'b1, k, bitrev3(k) * 100, -bitrev3(k) * 100);
      if (k == 7) last = cyc;
      tick();
      drive(1'b0, k, 12345, 12345);
    end
    repeat (12) tick();
    check_burst("s3", last + 2, 8, 0, 0);

    // Reset in the middle of a partial frame
    clear_cap();
    for (int k = 0; k < 4; k++) begin
      tick();
      drive(1'b1, k, 9999, 9999);
    end
    tick();
    drive(1'b0, 3, 0, 0);
    areset = 1'b0;
    #1;
    chk_outputs_zero("rst_mid");
    tick();
    chk_outputs_zero("rst_hold");
    areset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("s4_busy_low", v_t'(bus.busy), 0);
      drive(1'b1, k, bitrev3(k) * 100 + 7, -(bitrev3(k) * 100 + 7));
    end
    last = cyc;
    tick();
    drive(1'b0, 7, 0, 0);
    repeat (12) tick();
    check_burst("s4", last + 2, 8, 7, 7);

    // Full-scale values; source cnt is odd exactly when bin >= 4
    clear_cap();
    for (int k = 0; k < 8; k++) begin
      tick();
      v = (k % 2 == 1) ? 32767 : -32768;
      drive(1'b1, k, v, -v - 1);
    end
    last = cyc;
    tick();
    drive(1'b0, 7, 0, 0);
    repeat (12) tick();
    chk("s6_count", cap_cnt.size(), 8);
    for (int b = 0; b < 8 && b < cap_cnt.size(); b++) begin
      chk("s6_cycle", cap_cyc[b], last + 2 + b);
      chk("s6_cnt", cap_cnt[b], b);
      chk("s6_re", cap_re[b], (b >= 4) ? 32767 : -32768);
      chk("s6_im", cap_im[b], (b >= 4) ? -32768 : 32767);
    end

    repeat (5) tick();
    chk_outputs_en_idle: begin
      chk("end_en_out", v_t'(bus.en_out), 0);
      chk("end_busy", v_t'(bus.busy), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
